// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state control unit for the mini-SRC datapath.
// Every instruction starts with a three-state fetch (T0-T2) and then runs an
// opcode-dependent execute sequence (T3-T7). All outputs are Moore-decoded
// from the current state and the opcode held in IR.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        CONin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        done
);

    localparam logic [4:0] ADD_OP  = 5'b00011;
    localparam logic [4:0] AND_OP  = 5'b00101;
    localparam logic [4:0] OR_OP   = 5'b00110;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_ANDI = 5'b01001;
    localparam logic [4:0] OP_ORI  = 5'b01010;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    // Instruction classes sharing an execute sequence; nop covers undefined opcodes.
    typedef enum logic [2:0] {
        C_NOP, C_RTYPE, C_ITYPE, C_LDI, C_LD, C_ST, C_BR, C_HALT
    } iclass_t;

    state_t     state_q, state_d;
    iclass_t    iclass;
    logic [4:0] opcode;
    logic [4:0] imm_alu;
    logic       ir_unused;

    assign opcode    = IR[31:27];
    assign ir_unused = ^IR[26:0];

    // Opcode classification and ALU code selection for the immediate forms.
    always_comb begin
        iclass  = C_NOP;
        imm_alu = ADD_OP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: iclass = C_RTYPE;
            OP_ADDI: begin iclass = C_ITYPE; imm_alu = ADD_OP; end
            OP_ANDI: begin iclass = C_ITYPE; imm_alu = AND_OP; end
            OP_ORI:  begin iclass = C_ITYPE; imm_alu = OR_OP;  end
            OP_LDI:  iclass = C_LDI;
            OP_LD:   iclass = C_LD;
            OP_ST:   iclass = C_ST;
            OP_BR:   iclass = C_BR;
            OP_HALT: iclass = C_HALT;
            default: iclass = C_NOP;
        endcase
    end

    // State register; clear forces RST immediately, independent of the clock.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode from state and opcode class.
    always_comb begin
        state_d = state_q;
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        PCin    = 1'b0;
        IRin    = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        CONin   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        alu_op  = 5'b00000;
        run     = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_RST: state_d = S_T0;
            S_T0: begin
                run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                run     = 1'b1;
                state_d = S_T4;
                case (iclass)
                    C_RTYPE, C_ITYPE: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    C_HALT: state_d = S_HALT;
                    default: begin done = 1'b1; state_d = S_T0; end
                endcase
            end
            S_T4: begin
                run     = 1'b1;
                state_d = S_T5;
                case (iclass)
                    C_RTYPE: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    C_ITYPE: begin Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu; end
                    C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
                    C_BR:    begin PCout = 1'b1; Yin = 1'b1; end
                    default: state_d = S_T0;
                endcase
            end
            S_T5: begin
                run     = 1'b1;
                state_d = S_T0;
                case (iclass)
                    C_RTYPE, C_ITYPE, C_LDI: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                    end
                    C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; state_d = S_T6; end
                    C_BR: begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; state_d = S_T6; end
                    default: state_d = S_T0;
                endcase
            end
            S_T6: begin
                run     = 1'b1;
                state_d = S_T0;
                case (iclass)
                    C_LD: begin Read = 1'b1; MDRin = 1'b1; state_d = S_T7; end
                    C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = S_T7; end
                    // Branch target is always on the bus; PC only takes it when taken.
                    C_BR: begin Zlowout = 1'b1; PCin = CON; done = 1'b1; end
                    default: state_d = S_T0;
                endcase
            end
            S_T7: begin
                run     = 1'b1;
                state_d = S_T0;
                case (iclass)
                    C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
                    C_ST: begin Write = 1'b1; done = 1'b1; end
                    default: state_d = S_T0;
                endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the mini-SRC CPU datapath. It steps a one-hot-per-cycle T-state machine through fetch and execute for the implemented instruction subset. It drives the register-select strobes (Gra/Grb/Grc/Rin/Rout/BAout) consumed by the register select/encode logic, plus the bus-drive, register-load, memory and ALU-operation controls. Outputs are Moore-decoded from the current state and the opcode held in IR; memory is assumed to complete a read or write in one cycle.

## Interface
- ADD_OP, 5'b00011, ALU code for add; also used for address and branch-target computation
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-high reset
- IR  in  32  instruction register contents; opcode = IR[31:27]
- CON  in  1  branch-condition flip-flop output
- PCout, Zlowout, MDRout, Cout  out  1 each  bus drive enables
- PCin, IRin, MARin, MDRin, Yin, Zin, CONin  out  1 each  register load enables
- IncPC, Read, Write  out  1 each  PC increment and memory strobes
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  to register select/encode
- alu_op  out  5  ALU operation code
- run  out  1  high while executing; low in HALT
- done  out  1  one-cycle pulse in the last state of each instruction

## Operation
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01000, andi 01001, ori 01010, br 10010, nop 11010, halt 11011. Any other opcode is executed as nop.
- States: RST, T0–T7, HALT. Each state lasts one cycle. Outputs not listed for a state are 0. alu_op = 0 unless listed.
- RST: all outputs 0 and run=0; goes to T0 on the next edge.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- R-type (add/sub/and/or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin, done.
- I-type (addi/andi/ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op = 00011/00101/00110 respectively.
  - T5: Zlowout, Gra, Rin, done.
- ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op=ADD_OP.
  - T5: Zlowout, Gra, Rin, done.
- ld: T3–T4 as ldi, then:
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin, done.
- st: T3–T5 as ld, then:
  - T6: Gra, Rout, MDRin.
  - T7: Write, done.
- br:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, alu_op=ADD_OP.
  - T6: Zlowout, PCin only if CON=1; done.
- nop/undefined: T3: done.
- halt: T3 goes to HALT. HALT holds with all outputs 0, run=0, until clear.
- After a done state the next state is T0. run=1 in T0–T7.

## Timing
- State register updates on the rising edge of clock. Outputs are combinational from state and IR[31:27].
- Instruction length including fetch: R/I/ldi 6 cycles; ld/st 8; br 7; nop 4; halt 4 cycles to reach HALT.
- IR is loaded at the end of T2. Decode in T3 onward uses the new opcode; T0–T2 outputs are independent of IR.
- CON is loaded at the end of T3 and sampled combinationally in T6.
- clear asserted at any time: state goes to RST immediately and asynchronously, and every output is 0 in that same cycle. After clear deasserts, the first edge enters RST→T0 (the first edge out of reset lands in T0 if already in RST).
- Gra/Grb/Grc are mutually exclusive in every state. Rin and Rout/BAout are never asserted in the same state.

## Test plan
- Reset: clear=1 mid-T4 of add → all outputs 0 immediately, run=0. Release clear → T0 asserts PCout, MARin, IncPC, Zin.
- add R1,R2,R3 (IR=0x18918000) → over 6 cycles exactly the listed strobes appear. T4 shows alu_op=00011 with Grc and Rout. done=1 only in T5.
- ld R2,0x10(R1) (IR opcode 00000) → T3 BAout+Grb; T5 MARin; T6 Read+MDRin; T7 Gra+Rin+done; next cycle is T0.
- st then br: st → Write only in T7. br with CON=1 → PCin in T6. br with CON=0 → PCin=0 in T6, done=1, 7 cycles total.
- andi (01001) → alu_op=00101 in T4 with Cout=1. Undefined opcode 11111 → done in T3, next T0, no Rin/Write asserted.
- halt (11011) → HALT after T3, run=0 for 20+ cycles with all outputs 0. clear → restarts fetch.
